// File: rtl/ysyx_24110015_pkg.sv
// Shared types for the ysyx_24110015 memory arbiter: FSM states, request owner and
// the latched downstream command payload.
package ysyx_24110015_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned MW = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef struct packed {
    logic          wen;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } mem_cmd_t;

  // Width that holds 0..timeout; never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned timeout);
    return (timeout == 32'd0) ? 32'd1 : 32'($clog2(timeout + 32'd1));
  endfunction

endpackage

// File: rtl/ysyx_24110015_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant (bit0 = IF, bit1 = LS), last grant
// remembered so a tie goes to the requester that was not served last.
module ysyx_24110015_rr_arb2
  import ysyx_24110015_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt_c
);

  owner_e last_q, last_d;

  always_comb begin
    gnt_c = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt_c = (last_q == OWN_IF) ? 2'b10 : 2'b01;
      end else begin
        gnt_c = req;
      end
    end
  end

  // A grant is always a handshake, so it is safe to update history on it.
  always_comb begin
    last_d = last_q;
    if (gnt_c[1]) begin
      last_d = OWN_LS;
    end else if (gnt_c[0]) begin
      last_d = OWN_IF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_IF;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ysyx_24110015_mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one downstream memory
// port, one transaction at a time, with a WAIT timeout that returns an error response.
module ysyx_24110015_mem_arbiter
  import ysyx_24110015_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_valid,
  output logic          if_ready,
  input  logic [AW-1:0] if_addr,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_valid,
  output logic          ls_ready,
  input  logic [AW-1:0] ls_addr,
  input  logic          ls_wen,
  input  logic [DW-1:0] ls_wdata,
  input  logic [MW-1:0] ls_wmask,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_wdata,
  output logic [MW-1:0] mem_wmask,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  localparam int unsigned CW = cnt_width(TIMEOUT);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [AW-1:0] addr_q,  addr_d;
  mem_cmd_t      cmd_q,   cmd_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q,   err_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    gnt;
  logic          timeout_hit;

  ysyx_24110015_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == S_IDLE),
    .req   ({ls_valid, if_valid}),
    .gnt_c (gnt)
  );

  assign if_ready = gnt[0];
  assign ls_ready = gnt[1];

  // Leaving on the TIMEOUT-th WAIT cycle keeps the counter below TIMEOUT, so it never wraps.
  assign timeout_hit = (32'(cnt_q) + 32'd1) >= TIMEOUT;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (gnt[1]) begin
          owner_d     = OWN_LS;
          addr_d      = ls_addr;
          cmd_d.wen   = ls_wen;
          cmd_d.wdata = ls_wdata;
          cmd_d.wmask = ls_wmask;
          state_d     = S_REQ;
        end else if (gnt[0]) begin
          owner_d = OWN_IF;
          addr_d  = if_addr;
          cmd_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      cmd_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_valid = (state_q == S_REQ);
  assign mem_addr  = addr_q;
  assign mem_wen   = cmd_q.wen;
  assign mem_wdata = cmd_q.wdata;
  assign mem_wmask = cmd_q.wmask;

  assign if_rvalid = (state_q == S_RESP) && (owner_q == OWN_IF);
  assign ls_rvalid = (state_q == S_RESP) && (owner_q == OWN_LS);
  assign if_rdata  = rdata_q;
  assign ls_rdata  = rdata_q;
  assign err       = (state_q == S_RESP) && err_q;

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Scoreboard bench for ysyx_24110015_mem_arbiter: requester drivers, a delay-configurable
// memory model, a round-robin reference and per-response latency/data/err checks.
module tb_ysyx_24110015_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_addr = 32'h8000_0100;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_valid = 1'b0;
  logic        ls_ready;
  logic [31:0] ls_addr = 32'h8000_2000;
  logic        ls_wen = 1'b0;
  logic [31:0] ls_wdata = 32'h0;
  logic [7:0]  ls_wmask = 8'h0;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'hBAD0_BAD0;
  logic        err;

  always #5 clk = ~clk;

  ysyx_24110015_mem_arbiter #(.TIMEOUT(TO), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_addr(ls_addr), .ls_wen(ls_wen),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .err(err)
  );

  typedef struct {
    bit          is_ls;
    logic [31:0] addr;
    bit          wen;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    logic [31:0] rdata;
    bit          err;
    int unsigned lat;
    int unsigned hs_cyc;
  } txn_t;

  txn_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned if_todo = 0, ls_todo = 0;
  bit          if_hs = 0, ls_hs = 0;
  int unsigned ready_dly = 0, rsp_dly = 0;
  bit          silent = 0;
  bit          last_ls = 0;
  bit          exp_hs = 0;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Requester drivers: hold valid until the handshake, then advance to the next request.
  initial forever begin
    @(negedge clk);
    if (if_hs) begin
      if_hs = 0;
      if (if_todo > 0) if_todo--;
      if_addr = if_addr + 32'd4;
    end
    if_valid = (if_todo != 0) && !rst;
  end

  initial forever begin
    @(negedge clk);
    if (ls_hs) begin
      ls_hs = 0;
      if (ls_todo > 0) ls_todo--;
      ls_addr  = ls_addr + 32'd4;
      ls_wen   = ~ls_wen;
      ls_wdata = $urandom;
      ls_wmask = 8'($urandom_range(0, 255));
    end
    ls_valid = (ls_todo != 0) && !rst;
  end

  // Handshake monitor: round-robin reference, back-to-back grant, scoreboard push.
  always @(negedge clk) begin
    txn_t t;
    bit   g_ls;
    bit   hs;
    #2;
    if (rst) begin
      exp_hs = 0;
    end else begin
      hs = (if_valid && if_ready) || (ls_valid && ls_ready);
      if (if_ready && ls_ready) check("one_ready", 32'd1, 32'd0);
      if (exp_hs) check("b2b_grant", 32'(hs), 32'd1);
      exp_hs = (if_rvalid || ls_rvalid) && (if_valid || ls_valid);
      if (hs) begin
        g_ls = ls_valid && ls_ready;
        if (if_valid && ls_valid) check("rr_grant_ls", 32'(g_ls), 32'(!last_ls));
        last_ls  = g_ls;
        t.is_ls  = g_ls;
        t.addr   = g_ls ? ls_addr : if_addr;
        t.wen    = g_ls && ls_wen;
        t.wdata  = ls_wdata;
        t.wmask  = g_ls ? ls_wmask : 8'h00;
        t.err    = silent;
        t.rdata  = silent ? 32'h0 : data_of(t.addr);
        t.lat    = silent ? (2 + ready_dly + TO) : (3 + ready_dly + rsp_dly);
        t.hs_cyc = cyc;
        sb.push_back(t);
        if (g_ls) ls_hs = 1; else if_hs = 1;
      end
    end
  end

  // Response monitor: pop expected response and compare owner, data, err, latency.
  always @(negedge clk) begin
    txn_t t;
    if (!rst) begin
      if (if_rvalid || ls_rvalid) begin
        if (if_rvalid && ls_rvalid) check("both_rvalid", 32'd1, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          t = sb.pop_front();
          check("rvalid_is_ls", 32'(ls_rvalid), 32'(t.is_ls));
          check("rdata", t.is_ls ? ls_rdata : if_rdata, t.rdata);
          check("err", 32'(err), 32'(t.err));
          check("latency", cyc - t.hs_cyc, t.lat);
        end
      end else if (err) begin
        check("err_alone", 32'(err), 32'd0);
      end
    end
  end

  task automatic check_fields();
    if (sb.size() > 0) begin
      check("mem_valid", 32'(mem_valid), 32'd1);
      check("mem_addr", mem_addr, sb[0].addr);
      check("mem_wen", 32'(mem_wen), 32'(sb[0].wen));
      check("mem_wmask", 32'(mem_wmask), 32'(sb[0].wmask));
      if (sb[0].wen) check("mem_wdata", mem_wdata, sb[0].wdata);
    end
  endtask

  // Memory model: mem_ready after ready_dly REQ cycles, mem_rvalid rsp_dly cycles into WAIT.
  initial forever begin
    logic [31:0] a;
    @(negedge clk);
    if (mem_valid && !rst) begin
      a = (sb.size() > 0) ? sb[0].addr : 32'h0;
      for (int i = 0; i <= int'(ready_dly); i++) begin
        if (i != 0) @(negedge clk);
        check_fields();
      end
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      if (!silent) begin
        for (int i = 0; i < int'(rsp_dly); i++) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = data_of(a);
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hBAD0_BAD0;
      end
    end
  end

  task automatic wait_done(string tag);
    int n = 0;
    while ((if_todo != 0 || ls_todo != 0 || sb.size() != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 600), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_if_ready"}, 32'(if_ready), 32'd0);
    check({tag, "_ls_ready"}, 32'(ls_ready), 32'd0);
    check({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
    check({tag, "_ls_rvalid"}, 32'(ls_rvalid), 32'd0);
    check({tag, "_if_rdata"}, if_rdata, 32'd0);
    check({tag, "_ls_rdata"}, ls_rdata, 32'd0);
    check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_wmask"}, 32'(mem_wmask), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // Both requesters valid straight out of reset: LS first, IF right after.
    ls_wen = 1'b0;
    if_todo = 1;
    ls_todo = 1;
    wait_done("tie_done");

    // IF-only fetch with immediate memory: response 3 cycles after handshake.
    if_addr = 32'h8000_0000;
    if_todo = 1;
    wait_done("fetch_done");

    // Store with mem_ready held off 4 cycles: fields checked every REQ cycle.
    ls_addr   = 32'h8000_1000;
    ls_wen    = 1'b1;
    ls_wdata  = 32'hDEAD_BEEF;
    ls_wmask  = 8'h0F;
    ready_dly = 4;
    ls_todo   = 1;
    wait_done("store_done");

    // Both continuously valid for 10 transactions: strict alternation.
    ready_dly = 1;
    rsp_dly   = 2;
    if_todo   = 5;
    ls_todo   = 5;
    wait_done("alt_done");

    // No memory response: timeout after TO WAIT cycles with err and zero data.
    ready_dly = 0;
    rsp_dly   = 0;
    silent    = 1;
    ls_todo   = 1;
    wait_done("timeout_done");

    // Reset during WAIT, then a stray mem_rvalid: no response may appear.
    ls_todo = 1;
    n = 0;
    while (!mem_ready && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("reached_req", 32'(n < 100), 32'd1);
    repeat (2) @(negedge clk);
    rst     = 1'b1;
    ls_todo = 0;
    if_todo = 0;
    #1;
    check_zero_outputs("midrst");
    sb.delete();
    last_ls = 0;
    if_hs   = 0;
    ls_hs   = 0;
    @(negedge clk);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hBAD0_BAD0;
    silent     = 0;
    repeat (12) @(negedge clk);
    check("post_rst_err", 32'(err), 32'd0);
    check("post_rst_mem_valid", 32'(mem_valid), 32'd0);

    // FSM must be in IDLE: a fresh fetch completes with minimum latency.
    if_addr = 32'h8000_0000;
    if_todo = 1;
    wait_done("post_rst_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
